// File: rtl/bti_arb2_if.sv
// ---------------------------------------------------------------------------
// BTI bus interfaces used by bti_arb2.
//
// bti_req_if_t : request channel
//   vld  - request valid (master -> slave)
//   rdy  - request ready (slave -> master)
//   pkt  - {addr, tid} (master -> slave)
// bti_rsp_if_t : response channel
//   vld  - response valid (master -> slave)
//   rdy  - response ready (slave -> master)
//   pkt  - {data, tid, ok} (master -> slave)
// ---------------------------------------------------------------------------
interface bti_req_if_t #(
    parameter int AW = 32,
    parameter int TW = 4
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [TW-1:0] tid;
    } pkt_t;

    logic vld;
    logic rdy;
    pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t #(
    parameter int DW = 32,
    parameter int TW = 4
);
    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tid;
        logic          ok;
    } pkt_t;

    logic vld;
    logic rdy;
    pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_arb2.sv
// ---------------------------------------------------------------------------
// bti_arb2 - two-to-one BTI arbiter.
//
// Two requesters share one downstream BTI slave. Requests are granted
// round-robin; the grant is locked while the downstream request is stalled so
// the presented packet stays stable. Each accepted request's source port is
// pushed into an in-order FIFO so each response goes back to its issuer.
// No register stage in the data path: zero added latency both ways.
//
// Ports:
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   bti_req_slv0 - requester 0 request   (bti_req_if_t.slv)
//   bti_rsp_mst0 - requester 0 response  (bti_rsp_if_t.mst)
//   bti_req_slv1 - requester 1 request   (bti_req_if_t.slv)
//   bti_rsp_mst1 - requester 1 response  (bti_rsp_if_t.mst)
//   bti_req_mst  - shared downstream request  (bti_req_if_t.mst)
//   bti_rsp_slv  - shared downstream response (bti_rsp_if_t.slv)
//
// Build option:
//   BTI_ARB_FIXED_PRIO_EN - when defined, port 0 always wins when both ports
//   are valid (lock still applies) and the round-robin register is removed.
// ---------------------------------------------------------------------------
module bti_arb2 #(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32,
    parameter int BTI_TW = 4,
    parameter int OSD    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    bti_req_if_t.slv    bti_req_slv0,
    bti_rsp_if_t.mst    bti_rsp_mst0,
    bti_req_if_t.slv    bti_req_slv1,
    bti_rsp_if_t.mst    bti_rsp_mst1,
    bti_req_if_t.mst    bti_req_mst,
    bti_rsp_if_t.slv    bti_rsp_slv
);
    localparam int PW = (OSD > 1) ? $clog2(OSD) : 1;
    localparam int CW = $clog2(OSD + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e          lock_q, lock_d;
    logic           lock_id_q, lock_id_d;
    logic [OSD-1:0] src_q;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic vld0, vld1, gnt, pref, full, empty, head;
    logic req_vld, req_hs, rsp_rdy, rsp_hs;

    logic [BTI_AW-1:0] addr_sel;
    logic [BTI_TW-1:0] tid_sel;
    logic [BTI_DW-1:0] rsp_data;
    logic [BTI_TW-1:0] rsp_tid;
    logic              rsp_ok;

    assign vld0  = bti_req_slv0.vld;
    assign vld1  = bti_req_slv1.vld;
    assign full  = (cnt_q == CW'(OSD));
    assign empty = (cnt_q == '0);
    assign head  = src_q[rptr_q];

`ifdef BTI_ARB_FIXED_PRIO_EN
    assign pref = 1'b0;
`else
    logic rr_q;
    assign pref = rr_q;

    // Prefer the other port after every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (req_hs) begin
            rr_q <= ~gnt;
        end
    end
`endif

    // A stalled request keeps its grant; otherwise arbitrate.
    always_comb begin
        gnt = 1'b0;
        if (lock_q == LOCKED) begin
            gnt = lock_id_q;
        end else if (vld0 && vld1) begin
            gnt = pref;
        end else begin
            gnt = vld1;
        end
    end

    // Request path
    assign req_vld  = (vld0 | vld1) & ~full;
    assign req_hs   = req_vld & bti_req_mst.rdy;
    assign addr_sel = gnt ? bti_req_slv1.pkt.addr : bti_req_slv0.pkt.addr;
    assign tid_sel  = gnt ? bti_req_slv1.pkt.tid  : bti_req_slv0.pkt.tid;

    assign bti_req_mst.vld      = req_vld;
    assign bti_req_mst.pkt.addr = addr_sel;
    assign bti_req_mst.pkt.tid  = tid_sel;
    assign bti_req_slv0.rdy     = ~gnt & bti_req_mst.rdy & ~full;
    assign bti_req_slv1.rdy     =  gnt & bti_req_mst.rdy & ~full;

    // Lock FSM: next-state logic
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        case (lock_q)
            UNLOCKED: begin
                if (req_vld && !bti_req_mst.rdy) begin
                    lock_d    = LOCKED;
                    lock_id_d = gnt;
                end
            end
            LOCKED: begin
                if (req_hs) begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= UNLOCKED;
            lock_id_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Response path: routed by the oldest outstanding source entry.
    assign rsp_rdy  = ~empty & (head ? bti_rsp_mst1.rdy : bti_rsp_mst0.rdy);
    assign rsp_hs   = bti_rsp_slv.vld & rsp_rdy;
    assign rsp_data = bti_rsp_slv.pkt.data;
    assign rsp_tid  = bti_rsp_slv.pkt.tid;
    assign rsp_ok   = bti_rsp_slv.pkt.ok;

    assign bti_rsp_slv.rdy       = rsp_rdy;
    assign bti_rsp_mst0.vld      = bti_rsp_slv.vld & ~empty & ~head;
    assign bti_rsp_mst1.vld      = bti_rsp_slv.vld & ~empty &  head;
    assign bti_rsp_mst0.pkt.data = rsp_data;
    assign bti_rsp_mst0.pkt.tid  = rsp_tid;
    assign bti_rsp_mst0.pkt.ok   = rsp_ok;
    assign bti_rsp_mst1.pkt.data = rsp_data;
    assign bti_rsp_mst1.pkt.tid  = rsp_tid;
    assign bti_rsp_mst1.pkt.ok   = rsp_ok;

    // Source FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({req_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (req_hs) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rsp_hs) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Entry storage needs no reset: entries are only read while cnt_q > 0.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            src_q[wptr_q] <= gnt;
        end
    end

endmodule

// File: tb/tb_bti_arb2.sv
module tb_bti_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef BTI_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    // Expected grant of the second cycle of the alternation run.
    localparam bit G2 = FP ? 1'b0 : 1'b1;

    always #5 clk = ~clk;

    bti_req_if_t #(.AW(32), .TW(4)) req0 ();
    bti_req_if_t #(.AW(32), .TW(4)) req1 ();
    bti_req_if_t #(.AW(32), .TW(4)) reqm ();
    bti_rsp_if_t #(.DW(32), .TW(4)) rsp0 ();
    bti_rsp_if_t #(.DW(32), .TW(4)) rsp1 ();
    bti_rsp_if_t #(.DW(32), .TW(4)) rspm ();

    bti_arb2 #(.BTI_AW(32), .BTI_DW(32), .BTI_TW(4), .OSD(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bti_req_slv0 (req0),
        .bti_rsp_mst0 (rsp0),
        .bti_req_slv1 (req1),
        .bti_rsp_mst1 (rsp1),
        .bti_req_mst  (reqm),
        .bti_rsp_slv  (rspm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req0.vld = 0; req0.pkt = '0;
        req1.vld = 0; req1.pkt = '0;
        reqm.rdy = 0;
        rsp0.rdy = 0; rsp1.rdy = 0;
        rspm.vld = 0; rspm.pkt = '0;
        #12 rst_n = 1'b1;
        tick();

        // Reset then idle
        #1;
        chk("idle_mvld",  reqm.vld, 0);
        chk("idle_rdy0",  req0.rdy, 0);
        chk("idle_rdy1",  req1.rdy, 0);
        chk("idle_r0vld", rsp0.vld, 0);
        chk("idle_r1vld", rsp1.vld, 0);
        chk("idle_srdy",  rspm.rdy, 0);
        chk("idle_cnt",   dut.cnt_q, 0);

        // Both valid, alternation, 1-cycle responses
        req0.vld = 1; req0.pkt.addr = 32'h100; req0.pkt.tid = 4'h1;
        req1.vld = 1; req1.pkt.addr = 32'h200; req1.pkt.tid = 4'h2;
        reqm.rdy = 1; rsp0.rdy = 1; rsp1.rdy = 1;
        #1;
        chk("alt1_mvld", reqm.vld, 1);
        chk("alt1_addr", reqm.pkt.addr, 32'h100);
        chk("alt1_tid",  reqm.pkt.tid, 4'h1);
        chk("alt1_rdy0", req0.rdy, 1);
        chk("alt1_rdy1", req1.rdy, 0);
        tick();

        rspm.vld = 1; rspm.pkt.data = 32'hD0; rspm.pkt.tid = 4'h1; rspm.pkt.ok = 1;
        #1;
        chk("alt2_addr",  reqm.pkt.addr, G2 ? 32'h200 : 32'h100);
        chk("alt2_rdy1",  req1.rdy, G2);
        chk("alt2_r0vld", rsp0.vld, 1);
        chk("alt2_r1vld", rsp1.vld, 0);
        chk("alt2_r0tid", rsp0.pkt.tid, 4'h1);
        chk("alt2_srdy",  rspm.rdy, 1);
        tick();

        rspm.pkt.data = 32'hD1; rspm.pkt.tid = G2 ? 4'h2 : 4'h1;
        #1;
        chk("alt3_addr",  reqm.pkt.addr, 32'h100);
        chk("alt3_r0vld", rsp0.vld, !G2);
        chk("alt3_r1vld", rsp1.vld, G2);
        chk("alt3_r1dat", rsp1.pkt.data, 32'hD1);
        tick();

        req0.vld = 0; req1.vld = 0;
        rspm.pkt.data = 32'hD2; rspm.pkt.tid = 4'h1;
        #1;
        chk("alt4_r0vld", rsp0.vld, 1);
        chk("alt4_r1vld", rsp1.vld, 0);
        tick();
        rspm.vld = 0;
        #1;
        chk("alt_cnt0", dut.cnt_q, 0);

        // Back-pressure lock
        reqm.rdy = 0;
        req0.vld = 1; req0.pkt.addr = 32'h300; req0.pkt.tid = 4'h3;
        #1;
        chk("lk1_mvld", reqm.vld, 1);
        chk("lk1_addr", reqm.pkt.addr, 32'h300);
        chk("lk1_rdy0", req0.rdy, 0);
        tick();
        req1.vld = 1; req1.pkt.addr = 32'h400; req1.pkt.tid = 4'h4;
        #1;
        chk("lk2_addr", reqm.pkt.addr, 32'h300);
        chk("lk2_rdy1", req1.rdy, 0);
        tick();
        #1;
        chk("lk3_addr", reqm.pkt.addr, 32'h300);
        tick();
        reqm.rdy = 1;
        #1;
        chk("lk4_addr", reqm.pkt.addr, 32'h300);
        chk("lk4_rdy0", req0.rdy, 1);
        chk("lk4_rdy1", req1.rdy, 0);
        tick();
        req0.vld = 0;
        #1;
        chk("lk5_addr", reqm.pkt.addr, 32'h400);
        chk("lk5_rdy1", req1.rdy, 1);
        tick();
        req1.vld = 0;

        // FIFO full (two outstanding, no responses yet)
        req0.vld = 1; req0.pkt.addr = 32'h500; req0.pkt.tid = 4'h5;
        #1;
        chk("full_cnt",  dut.cnt_q, 2);
        chk("full_mvld", reqm.vld, 0);
        chk("full_rdy0", req0.rdy, 0);
        tick();
        rspm.vld = 1; rspm.pkt.data = 32'hCAFE; rspm.pkt.tid = 4'h3;
        #1;
        chk("full_r0vld",  rsp0.vld, 1);
        chk("full_r1dat",  rsp1.pkt.data, 32'hCAFE);
        chk("full_nobyp",  reqm.vld, 0);
        tick();
        rspm.vld = 0;
        #1;
        chk("rel_mvld", reqm.vld, 1);
        chk("rel_rdy0", req0.rdy, 1);
        chk("rel_addr", reqm.pkt.addr, 32'h500);
        tick();
        #1;
        chk("refull_mvld", reqm.vld, 0);
        req0.vld = 0;

        // In-order response back-pressure: queue is [port1, port0]
        rsp0.rdy = 1; rsp1.rdy = 0;
        rspm.vld = 1; rspm.pkt.tid = 4'h4;
        #1;
        chk("ord_r1vld", rsp1.vld, 1);
        chk("ord_r0vld", rsp0.vld, 0);
        chk("ord_srdy",  rspm.rdy, 0);
        tick();
        #1;
        chk("ord_cnt", dut.cnt_q, 2);
        rsp1.rdy = 1;
        #1;
        chk("ord_srdy1", rspm.rdy, 1);
        tick();
        rspm.pkt.tid = 4'h5;
        #1;
        chk("ord2_r0vld", rsp0.vld, 1);
        chk("ord2_r1vld", rsp1.vld, 0);
        tick();
        #1;
        chk("ord_cnt0",  dut.cnt_q, 0);
        chk("emp_srdy",  rspm.rdy, 0);
        chk("emp_r0vld", rsp0.vld, 0);
        chk("emp_r1vld", rsp1.vld, 0);
        rspm.vld = 0;

        // Asynchronous reset mid-transaction
        req0.vld = 1; req0.pkt.addr = 32'h600;
        tick();
        #1;
        chk("mr_cnt1", dut.cnt_q, 1);
        req0.vld = 0;
        rst_n = 1'b0;
        #1;
        chk("mr_cnt0", dut.cnt_q, 0);
        chk("mr_wptr", dut.wptr_q, 0);
        chk("mr_empty_rsp", rspm.rdy, 0);
        #3 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bti_arb2.md
# bti_arb2

Two-to-one arbiter for the BTI bus. It lets two requesters share one BTI slave, for example instruction fetch and data load sharing `bti_rom`. Requests are granted round-robin, and the grant is held stable under back-pressure. Each accepted request's source is recorded in an in-order tracking FIFO, so every downstream response is returned to the requester that issued it. The block sits between the masters and the slave's `bti_req_slv` / `bti_rsp_mst` ports.

## Interface
- `BTI_AW`, 32, BTI address width (passed through, not decoded)
- `BTI_DW`, 32, BTI data width (passed through)
- `OSD`, 2, maximum outstanding downstream requests; power of two, ≥ 2

- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `bti_req_slv0`  `bti_req_if_t.slv`  —  requester 0 request (`vld`, `rdy`, `pkt.addr`, `pkt.tid`)
- `bti_rsp_mst0`  `bti_rsp_if_t.mst`  —  requester 0 response (`vld`, `rdy`, `pkt.data`, `pkt.tid`, `pkt.ok`)
- `bti_req_slv1`  `bti_req_if_t.slv`  —  requester 1 request
- `bti_rsp_mst1`  `bti_rsp_if_t.mst`  —  requester 1 response
- `bti_req_mst`  `bti_req_if_t.mst`  —  shared downstream request
- `bti_rsp_slv`  `bti_rsp_if_t.slv`  —  shared downstream response

## Operation
**State**
- `rr`: 1 bit, the preferred port.
- `lock`: 1 bit, plus `lock_id`: 1 bit.
- Source FIFO: `OSD` entries × 1 bit, with `cnt` ranging 0..`OSD`.

**Grant**
- If `lock` = 1: `gnt` = `lock_id`.
- Otherwise, if both ports are valid: `gnt` = `rr`.
- Otherwise: `gnt` = the single valid port.

**Request path (combinational)**
- `bti_req_mst.vld` = (`vld0` | `vld1`) & !full.
- `bti_req_mst.pkt` = `pkt` of the granted port.
- `rdyN` = (`gnt` == N) & `bti_req_mst.rdy` & !full.

**Lock FSM**
- UNLOCKED → LOCKED when `bti_req_mst.vld` & !`bti_req_mst.rdy`. `lock_id` captures `gnt` at that point.
- LOCKED → UNLOCKED on downstream request handshake.
- This keeps `pkt` stable while `vld` is held, as BTI requires.

**Round-robin**
- On each downstream request handshake, `rr` ← !`gnt`.

**Source FIFO**
- Push `gnt` on request handshake.
- Pop on `bti_rsp_slv` handshake.
- Full (`cnt` == `OSD`) blocks new requests. There is no same-cycle bypass when full, even if a pop occurs that cycle.

**Response path (combinational)**
- `bti_rsp_mstN.vld` = `bti_rsp_slv.vld` & !empty & (head == N).
- `pkt` is broadcast to both response ports.
- `bti_rsp_slv.rdy` = !empty & `rdy` of the response port selected by head.
- A response arriving while the FIFO is empty is not accepted (`rdy` = 0); it is a protocol error.

**Arithmetic**
- Read/write pointers are `$clog2(OSD)` bits and wrap naturally.
- Push and pop in the same cycle leave `cnt` unchanged.

## Timing
- Zero added latency on both the request and response paths; the block has no register stage in the data path.
- Reset values:
  - `rr` = 0 (port 0 preferred first), `lock` = 0, `cnt` = 0, pointers = 0.
  - Consequently all `vld`/`rdy` outputs are 0 until an input is valid.
- Accepted requests: at most one per cycle.
- Round trip through `bti_rom` (1-cycle response from its reg slice): request at cycle T, response at T+1.
- Back-to-back alternation 0,1,0,1 is sustained at one request per cycle when `OSD` ≥ 2 and the slave drains one response per cycle.
- Reset asserted mid-transaction:
  - All state clears immediately.
  - Outstanding responses are forgotten; the downstream slave must also be reset.

## Configuration
- `BTI_ARB_FIXED_PRIO_EN`
  - **Defined:** port 0 always wins when both ports are valid (lock still applies); the `rr` register is removed.
  - **Undefined (default):** round-robin as described above.

## Test plan
- Reset then idle → all `vld` and `rdy` outputs are 0; `cnt` = 0.
- Both ports valid continuously, `addr0` = 0x100 and `addr1` = 0x200, slave always ready, 1-cycle response → downstream sees 0x100, 0x200, 0x100, …; each response returns only to its issuer with matching `tid`.
- Port 0 valid with `bti_req_mst.rdy` held at 0 for 3 cycles while port 1 asserts at cycle 1 → grant stays on port 0; `pkt` is stable; port 1 is granted on the cycle after port 0's handshake.
- Slave never responds, `OSD` = 2 → exactly 2 requests accepted; `bti_req_mst.vld` = 0 afterwards; one response releases exactly one more request.
- Requester 1's `rsp` `rdy` = 0 while the head entry belongs to port 1 → `bti_rsp_slv.rdy` = 0; a response for port 0 queued behind it is not delivered (in-order).
- With `BTI_ARB_FIXED_PRIO_EN` defined and both ports always valid → only port 0 is granted.
